// File: rtl/fft_stage_sequencer_if.sv
// Handshake/bus bundle between the FFT sequencer and the butterfly datapath.
// The sequencer owns every signal except start.
interface fft_stage_sequencer_if #(
  parameter int LOG2N = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic [2:0]       stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             stage_done;

  modport master (
    input  start,
    output busy, done, stage,
    output rd_en, rd_addr_a, rd_addr_b, tw_idx,
    output wr_en, wr_addr_a, wr_addr_b, stage_done
  );

  modport slave (
    output start,
    input  busy, done, stage,
    input  rd_en, rd_addr_a, rd_addr_b, tw_idx,
    input  wr_en, wr_addr_a, wr_addr_b, stage_done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Reads issue one per cycle; write-backs follow BF_LAT cycles later.
module fft_stage_sequencer #(
  parameter int LOG2N  = 5,
  parameter int BF_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  fft_stage_sequencer_if.master  bus
);
  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0] KMAX = '1;
  localparam logic [2:0] SMAX = 3'(LOG2N - 1);
  localparam logic [3:0] DLAT = 4'(BF_LAT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic             v;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic             last;
  } wb_t;

  state_e           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [3:0]       drn_q, drn_d;

  logic             busy_q, done_q;
  logic [2:0]       stage_q;
  logic             rd_en_q, last_q;
  logic [LOG2N-1:0] rd_a_q, rd_b_q;
  logic [KW-1:0]    tw_q;
  wb_t              dl_q [BF_LAT];

  logic [LOG2N-1:0] kx, span, pos, a_d, b_d;
  logic [KW-1:0]    tw_d;
  logic             run_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k_q == KMAX) begin
          state_d = DRAIN;
          drn_d   = DLAT;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == 4'd1) begin
          drn_d = '0;
          if (s_q != SMAX) begin
            state_d = RUN;
            s_d     = s_q + 3'd1;
            k_d     = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          drn_d = drn_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses for the read the next cycle will present.
  always_comb begin
    run_d = (state_d == RUN);
    kx    = {1'b0, k_d};
    span  = LOG2N'(1) << s_d;
    pos   = kx & (span - LOG2N'(1));
    a_d   = ((kx >> s_d) << (s_d + 3'd1)) | pos;
    b_d   = a_d | span;
    tw_d  = KW'(pos << (SMAX - s_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      drn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      last_q  <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      drn_q   <= drn_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      stage_q <= s_d;
      rd_en_q <= run_d;
      last_q  <= run_d && (k_d == KMAX);
      rd_a_q  <= run_d ? a_d : '0;
      rd_b_q  <= run_d ? b_d : '0;
      tw_q    <= run_d ? tw_d : '0;
    end
  end

  // Write-back delay line; its tail is the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= '{v: rd_en_q, a: rd_a_q, b: rd_b_q, last: last_q};
      for (int i = 1; i < BF_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stage      = stage_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr_a  = rd_a_q;
  assign bus.rd_addr_b  = rd_b_q;
  assign bus.tw_idx     = tw_q;
  assign bus.wr_en      = dl_q[BF_LAT-1].v;
  assign bus.wr_addr_a  = dl_q[BF_LAT-1].a;
  assign bus.wr_addr_b  = dl_q[BF_LAT-1].b;
  assign bus.stage_done = dl_q[BF_LAT-1].v & dl_q[BF_LAT-1].last;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: default and LOG2N=3/BF_LAT=1 instances
// checked cycle by cycle against a schedule model.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.LOG2N(5)) ifa ();
  fft_stage_sequencer_if #(.LOG2N(3)) ifb ();

  fft_stage_sequencer #(.LOG2N(5), .BF_LAT(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  fft_stage_sequencer #(.LOG2N(3), .BF_LAT(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  typedef struct {
    logic [31:0] busy, done, stage, rd_en, ra, rb, tw;
    logic [31:0] wr_en, wa, wb, sd;
  } obs_t;

  int sp_w  [4] = '{0, 0, 0, 1};
  int sp_t  [4] = '{4, 44, 92, 12};
  int sp_a  [4] = '{6, 9, 15, 1};
  int sp_b  [4] = '{7, 13, 31, 5};
  int sp_tw [4] = '{0, 4, 15, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input int t,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) ifa.start = v;
    else        ifb.start = v;
  endtask

  function automatic obs_t get_obs(input int w);
    obs_t o;
    if (w == 0) begin
      o.busy = 32'(ifa.busy);       o.done = 32'(ifa.done);
      o.stage = 32'(ifa.stage);     o.rd_en = 32'(ifa.rd_en);
      o.ra = 32'(ifa.rd_addr_a);    o.rb = 32'(ifa.rd_addr_b);
      o.tw = 32'(ifa.tw_idx);       o.wr_en = 32'(ifa.wr_en);
      o.wa = 32'(ifa.wr_addr_a);    o.wb = 32'(ifa.wr_addr_b);
      o.sd = 32'(ifa.stage_done);
    end else begin
      o.busy = 32'(ifb.busy);       o.done = 32'(ifb.done);
      o.stage = 32'(ifb.stage);     o.rd_en = 32'(ifb.rd_en);
      o.ra = 32'(ifb.rd_addr_a);    o.rb = 32'(ifb.rd_addr_b);
      o.tw = 32'(ifb.tw_idx);       o.wr_en = 32'(ifb.wr_en);
      o.wa = 32'(ifb.wr_addr_a);    o.wb = 32'(ifb.wr_addr_b);
      o.sd = 32'(ifb.stage_done);
    end
    return o;
  endfunction

  // Butterfly k of stage s, straight from the radix-2 index rules.
  task automatic addr(input int lg, input int s, input int k,
                      output int a, output int b, output int tw);
    int span;
    span = 1 << s;
    a  = (k / span) * 2 * span + (k % span);
    b  = a + span;
    tw = ((k % span) << (lg - 1 - s)) % (1 << (lg - 1));
  endtask

  // Expected outputs t cycles after the start-sampling edge.
  task automatic exp_obs(input int lg, input int bl, input int t,
                         output obs_t o);
    int h, p, tot, s, r, tr, a, b, tw;
    h = (1 << lg) / 2;
    p = h + bl;
    tot = lg * p;
    o = '{default: 0};
    o.busy = 32'(t >= 1 && t <= tot);
    o.done = 32'(t == tot + 1);
    if (t >= 1 && t <= tot) begin
      s = (t - 1) / p;
      r = (t - 1) % p;
      o.stage = s;
      if (r < h) begin
        addr(lg, s, r, a, b, tw);
        o.rd_en = 1; o.ra = a; o.rb = b; o.tw = tw;
      end
    end
    tr = t - bl;
    if (tr >= 1 && tr <= tot) begin
      s = (tr - 1) / p;
      r = (tr - 1) % p;
      if (r < h) begin
        addr(lg, s, r, a, b, tw);
        o.wr_en = 1; o.wa = a; o.wb = b;
        o.sd = 32'(r == h - 1);
      end
    end
  endtask

  task automatic cmp_obs(input int w, input int lg, input int bl,
                         input int t);
    obs_t e, g;
    exp_obs(lg, bl, t, e);
    g = get_obs(w);
    cmp("busy", t, g.busy, e.busy);
    cmp("done", t, g.done, e.done);
    cmp("rd_en", t, g.rd_en, e.rd_en);
    cmp("wr_en", t, g.wr_en, e.wr_en);
    cmp("stage_done", t, g.sd, e.sd);
    if (e.busy == 1) cmp("stage", t, g.stage, e.stage);
    if (e.rd_en == 1) begin
      cmp("rd_addr_a", t, g.ra, e.ra);
      cmp("rd_addr_b", t, g.rb, e.rb);
      cmp("tw_idx", t, g.tw, e.tw);
    end
    if (e.wr_en == 1) begin
      cmp("wr_addr_a", t, g.wa, e.wa);
      cmp("wr_addr_b", t, g.wb, e.wb);
    end
  endtask

  task automatic spot(input int w, input int t);
    obs_t g;
    g = get_obs(w);
    for (int i = 0; i < 4; i++) begin
      if (sp_w[i] == w && sp_t[i] == t) begin
        cmp("spot_rd_en", t, g.rd_en, 1);
        cmp("spot_a", t, g.ra, sp_a[i]);
        cmp("spot_b", t, g.rb, sp_b[i]);
        cmp("spot_tw", t, g.tw, sp_tw[i]);
      end
    end
  endtask

  task automatic check_zero(input int w, input int t);
    obs_t g;
    g = get_obs(w);
    cmp("z_busy", t, g.busy, 0);   cmp("z_done", t, g.done, 0);
    cmp("z_stage", t, g.stage, 0); cmp("z_rd_en", t, g.rd_en, 0);
    cmp("z_ra", t, g.ra, 0);       cmp("z_rb", t, g.rb, 0);
    cmp("z_tw", t, g.tw, 0);       cmp("z_wr_en", t, g.wr_en, 0);
    cmp("z_wa", t, g.wa, 0);       cmp("z_wb", t, g.wb, 0);
    cmp("z_sd", t, g.sd, 0);
  endtask

  task automatic run(input int w, input int lg, input int bl,
                     input bit poke);
    int tot, nb, nw, nd, ns;
    obs_t g;
    tot = lg * ((1 << lg) / 2 + bl);
    nb = 0; nw = 0; nd = 0; ns = 0;
    set_start(w, 1'b1);
    tick();
    for (int t = 1; t <= tot + 4; t++) begin
      if (poke && t <= tot) set_start(w, 1'($urandom_range(0, 1)));
      else                  set_start(w, 1'b0);
      cmp_obs(w, lg, bl, t);
      spot(w, t);
      g = get_obs(w);
      nb += int'(g.busy == 1);
      nw += int'(g.wr_en == 1);
      nd += int'(g.done == 1);
      ns += int'(g.sd == 1);
      tick();
    end
    set_start(w, 1'b0);
    cmp("busy_cycles", tot, nb, tot);
    cmp("wr_count", tot, nw, lg * (1 << lg) / 2);
    cmp("done_count", tot, nd, 1);
    cmp("stage_done_count", tot, ns, lg);
  endtask

  initial begin
    int tot, tr;
    obs_t g;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) tick();
    check_zero(0, 0);
    check_zero(1, 0);
    rst = 1'b0;
    tick();

    repeat ($urandom_range(1, 5)) tick();
    run(0, 5, 3, 1'b0);

    repeat ($urandom_range(1, 5)) tick();
    run(0, 5, 3, 1'b1);

    // start held high: a second transform follows the idle cycle
    tot = 5 * (16 + 3);
    set_start(0, 1'b1);
    tick();
    for (int t = 1; t <= tot + 2; t++) begin
      cmp_obs(0, 5, 3, t);
      tick();
    end
    g = get_obs(0);
    cmp("retrig_rd_en", tot + 3, g.rd_en, 1);
    cmp("retrig_busy", tot + 3, g.busy, 1);
    cmp("retrig_stage", tot + 3, g.stage, 0);
    cmp("retrig_ra", tot + 3, g.ra, 0);
    set_start(0, 1'b0);
    rst = 1'b1;
    tick();
    check_zero(0, -1);
    rst = 1'b0;
    tick();

    // asynchronous abort somewhere inside stage 2
    tr = 2 * 19 + 1 + $urandom_range(0, 18);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    for (int t = 1; t <= tr; t++) begin
      cmp_obs(0, 5, 3, t);
      if (t < tr) tick();
    end
    #2 rst = 1'b1;
    #1 check_zero(0, tr);
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      g = get_obs(0);
      cmp("post_rst_wr_en", t, g.wr_en, 0);
      cmp("post_rst_done", t, g.done, 0);
      cmp("post_rst_busy", t, g.busy, 0);
      tick();
    end
    run(0, 5, 3, 1'b0);

    repeat ($urandom_range(1, 5)) tick();
    run(1, 3, 1, 1'b0);
    run(1, 3, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control FSM for the in-place radix-2 DIT FFT core.
- On `start`, walks all LOG2N stages. For each stage it issues one butterfly read per cycle, with A/B operand addresses and a twiddle index.
- Issues the matching write-backs BF_LAT cycles later, and drains the butterfly pipeline between stages to avoid read-after-write hazards.
- Reports completion with a `busy`/`done` handshake.

Parameters:
- LOG2N, 5, log2 of FFT length N; N=32 by default, giving stages 0..4.
- BF_LAT, 3, butterfly read-to-write latency in cycles; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a transform; sampled only in IDLE
- busy  out  1  high while a transform is in progress
- done  out  1  one-cycle pulse when the transform completes
- stage  out  3  stage index of the current read
- rd_en  out  1  butterfly read strobe
- rd_addr_a  out  LOG2N  operand A address
- rd_addr_b  out  LOG2N  operand B address
- tw_idx  out  LOG2N-1  twiddle ROM index, aligned with rd_en
- wr_en  out  1  write-back strobe
- wr_addr_a  out  LOG2N  write-back address for result A
- wr_addr_b  out  LOG2N  write-back address for result B
- stage_done  out  1  one-cycle pulse on the final write of each stage

Behaviour:
- Reset (async, rst=1):
  - All outputs 0, FSM in IDLE, internal counters 0.
  - Write delay line cleared, so pending writes are discarded.
  - Reset mid-transform aborts the transform; no `done` is issued.
- States:
  - IDLE: start=1 -> RUN with s=0, k=0.
  - RUN: one read per cycle, k = 0..N/2-1. After k=N/2-1 -> DRAIN, with the drain counter loaded to BF_LAT.
  - DRAIN: no reads for BF_LAT cycles. Then, if s<LOG2N-1: s++, k=0, -> RUN; otherwise -> DONE.
  - DONE: lasts one cycle; done=1, busy=0; -> IDLE.
- All outputs are registered. The first rd_en appears the cycle after start is sampled.
- busy=1 in RUN and DRAIN only.
- start is ignored while not in IDLE. start held high re-triggers a new transform the cycle after DONE.
- Address generation, for stage s and butterfly k:
  - span = 2^s; pos = k mod span; grp = k >> s.
  - rd_addr_a = grp*2*span + pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_idx = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
  - All address arithmetic is unsigned; no value exceeds N-1.
- Write side:
  - A BF_LAT-deep shift line carries {valid, addr_a, addr_b, last-of-stage}.
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed exactly BF_LAT cycles.
  - stage_done is asserted together with the wr_en of k=N/2-1.
- Hazard rule: the last write of stage s occurs on the final DRAIN cycle; the first read of stage s+1 is on the following cycle.
- Timing:
  - Per-stage period is N/2+BF_LAT cycles.
  - busy stays high for LOG2N*(N/2+BF_LAT) cycles; 95 cycles at the defaults.
  - done pulses the cycle after the final wr_en.
- Counters:
  - k is LOG2N-1 bits and wraps to 0 at the stage boundary.
  - s stops at LOG2N-1 and never wraps.
  - The stage port carries s zero-extended to 3 bits.

Test Plan:
- Reset then single start pulse (defaults):
  - rd_en first seen 1 cycle after start; busy high for exactly 95 cycles.
  - done pulses once at cycle 96 after start; wr_en is high in 80 cycles total.
- Address check, defaults:
  - Stage 0, k=3: a=6, b=7, tw=0.
  - Stage 2, k=5: a=9, b=13, tw=4.
  - Stage 4, k=15: a=15, b=31, tw=15.
  - Each wr_addr matches the rd_addr from exactly 3 cycles earlier.
- Stage boundary:
  - stage_done coincides with the final wr_en of each stage, 5 pulses in total.
  - The next stage's first rd_en is on the cycle after each stage_done; no read and write for the same stage overlap.
- start pulsed repeatedly during busy: no effect; the transform still finishes in 95 cycles with a single done.
- Async rst asserted mid-stage 2 (between clock edges): all outputs 0 immediately; no further wr_en or done; a subsequent start runs a full clean transform.
- Parameter sweep LOG2N=3, BF_LAT=1: busy for 3*(4+1)=15 cycles; stage 2, k=1 gives a=1, b=5, tw=1.
